// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer driving the select of a shared 4:1 datapath mux.
// Grants one requester at a time, holds until done/drop/timeout, always idles one cycle between owners.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    input  logic       done_i,
    output logic [3:0] grant_o,
    output logic [1:0] sel_o,
    output logic       busy_o,
    output logic       timeout_o
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic               pick_vld_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic               owner_req_c;
    logic               hold_limit_c;
    logic               release_c;
    logic               timeout_c;

    // First requester at or after the priority pointer, wrapping modulo N_REQ.
    always_comb begin
        logic [IDX_W-1:0] cand;
        pick_vld_c = 1'b0;
        pick_idx_c = ptr_q;
        cand       = ptr_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!pick_vld_c && req_i[cand]) begin
                pick_vld_c = 1'b1;
                pick_idx_c = cand;
            end
        end
    end

    // sel_q doubles as the owner index while holding.
    always_comb begin
        owner_req_c  = req_i[sel_q];
        hold_limit_c = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD - 1));
        release_c    = done_i || !owner_req_c || hold_limit_c;
        timeout_c    = hold_limit_c && !done_i && owner_req_c;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_vld_c) state_d = ST_HOLD;
            ST_HOLD: if (release_c)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath state.
    always_comb begin
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_c) begin
                    grant_d = N_REQ'(1) << pick_idx_c;
                    sel_d   = pick_idx_c;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (release_c) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = sel_q + IDX_W'(1);
                    timeout_d = timeout_c;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign grant_o   = grant_q;
    assign sel_o     = sel_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

    a_grant_onehot0: assert property (@(posedge clk_i) disable iff (!rst_i)
        $onehot0(grant_q));
    a_busy_matches: assert property (@(posedge clk_i) disable iff (!rst_i)
        busy_q == (|grant_q));
    a_sel_is_owner: assert property (@(posedge clk_i) disable iff (!rst_i)
        busy_q |-> grant_q[sel_q]);
    a_no_direct_handoff: assert property (@(posedge clk_i) disable iff (!rst_i)
        (busy_q && $past(busy_q)) |-> (grant_q == $past(grant_q)));

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, corner sequences, random vs. reference model.
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 15;
    localparam int N_VEC    = 18;
    localparam int N_RAND   = 3000;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] req_i;
    logic       done_i;
    logic [3:0] grant_o;
    logic [1:0] sel_o;
    logic       busy_o;
    logic       timeout_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t vecs [N_VEC];

    // Reference model: owner index, cycles held so far, priority pointer.
    int         m_owner;
    int         m_held;
    int         m_ptr;
    logic       m_busy;
    logic       m_to;
    logic [1:0] m_sel;

    mux_rr_arbiter #(.MAX_HOLD(15), .CNT_W(4)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .done_i    (done_i),
        .grant_o   (grant_o),
        .sel_o     (sel_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] es,
                       input logic eb, input logic et);
        total++;
        if (grant_o !== eg || sel_o !== es || busy_o !== eb || timeout_o !== et) begin
            bad++;
            $display("FAIL %s: got grant=%b sel=%0d busy=%b timeout=%b, want grant=%b sel=%0d busy=%b timeout=%b",
                     name, grant_o, sel_o, busy_o, timeout_o, eg, es, eb, et);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_held  = 0;
        m_ptr   = 0;
        m_busy  = 1'b0;
        m_to    = 1'b0;
        m_sel   = 2'd0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic d);
        bit found;
        bit lim;
        m_to = 1'b0;
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (!found && r[c]) begin
                    found   = 1;
                    m_owner = c;
                    m_sel   = 2'(c);
                    m_busy  = 1'b1;
                    m_held  = 1;
                end
            end
        end else begin
            lim = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
            if (d || !r[m_owner] || lim) begin
                m_to   = lim && !d && r[m_owner];
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % 4;
            end else begin
                m_held++;
            end
        end
    endtask

    initial begin
        logic [3:0] rq;
        logic [3:0] eg;

        // Rotation and wrap, then request drop, then wrapped single-requester search.
        vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[6]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[7]  = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[8]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[9]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[10] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[11] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[12] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[13] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[14] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[15] = '{4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
        vecs[16] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[17] = '{4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};

        rst_i  = 1'b0;
        req_i  = 4'b0000;
        done_i = 1'b0;
        #1;
        chk("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
        #20;
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            req_i  = vecs[i].req;
            done_i = vecs[i].done;
            step();
            chk($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].busy, vecs[i].to);
        end

        // Timeout: grant high for exactly MAX_HOLD cycles, one-cycle pulse, then re-grant.
        req_i  = 4'b0001;
        done_i = 1'b0;
        step();
        chk("to_hold_1", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int c = 2; c <= MAX_HOLD; c++) begin
            step();
            chk($sformatf("to_hold_%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step();
        chk("to_release", 4'b0000, 2'd0, 1'b0, 1'b1);
        step();
        chk("to_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // done_i on the final allowed hold cycle is a normal release.
        for (int c = 2; c <= MAX_HOLD; c++) begin
            step();
        end
        chk("done_hold_15", 4'b0001, 2'd0, 1'b1, 1'b0);
        done_i = 1'b1;
        step();
        chk("done_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Asynchronous reset while requester 3 owns the mux.
        done_i = 1'b0;
        req_i  = 4'b1000;
        step();
        chk("pre_reset_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        #3;
        rst_i = 1'b0;
        #1;
        chk("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        req_i = 4'b1111;
        step();
        chk("post_reset_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Randomized traffic against the reference model, from a fresh reset.
        rst_i = 1'b0;
        req_i = 4'b0000;
        #7;
        chk("rand_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        model_reset();
        rq = 4'b0000;
        for (int n = 0; n < N_RAND; n++) begin
            for (int b = 0; b < 4; b++) begin
                if (rq[b]) begin
                    if ($urandom_range(15, 0) == 0) rq[b] = 1'b0;
                end else begin
                    if ($urandom_range(3, 0) == 0) rq[b] = 1'b1;
                end
            end
            req_i  = rq;
            done_i = ($urandom_range(19, 0) == 0);
            step();
            model_edge(req_i, done_i);
            eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
            chk($sformatf("rand%0d", n), eg, m_sel, m_busy, m_to);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 32-bit 4:1 datapath mux.
- Four requesters compete for one shared resource, such as a memory or write-back port.
- The block grants one requester at a time and drives the mux select. It holds the grant until the transaction ends and forces release on a hold timeout.
- It sits between the requester control logic and the mux select input.

Parameters:
MAX_HOLD, 15, maximum consecutive cycles a grant may be held before forced release; 0 disables the timeout.
CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous active-low reset.
req_i  input  4  request per requester; a requester holds its bit high for the whole transaction.
done_i  input  1  current owner's transaction completes this cycle.
grant_o  output  4  one-hot grant, registered; 0 when idle.
sel_o  output  2  mux select equal to the index of the current or last owner, registered.
busy_o  output  1  high while a grant is active.
timeout_o  output  1  one-cycle pulse on forced release.

Behaviour:
- Clocking and reset:
  - One clock, clk_i.
  - Reset is asynchronous and active-low on rst_i.
  - All state and outputs are registered.
- Reset values:
  - grant_o=0, sel_o=0, busy_o=0, timeout_o=0.
  - state=IDLE, priority pointer ptr=0, hold_cnt=0.
- States: IDLE, HOLD.
- IDLE:
  - If req_i != 0, choose the first set bit searching ptr, ptr+1, ... modulo 4.
  - At the next edge, enter HOLD with grant_o set to the one-hot owner, sel_o=owner, busy_o=1, hold_cnt=0.
  - Grant latency is exactly 1 cycle from req_i sampled.
  - done_i is ignored in IDLE.
- HOLD, evaluated at each edge:
  - Release when done_i=1, or req_i[owner]=0, or (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1).
  - Otherwise hold_cnt increments, saturating at all-ones.
  - Result: without early release, grant stays high for exactly MAX_HOLD cycles.
- On release (next edge):
  - state=IDLE, grant_o=0, busy_o=0, ptr=(owner+1) mod 4.
  - sel_o holds its value, so the mux select never glitches while idle.
  - timeout_o=1 for one cycle only if the release cause was the timeout alone.
- Mandatory bubble: at least one IDLE cycle between consecutive grants. grant_o never changes directly from one owner to another.
- Simultaneous events:
  - done_i together with the timeout condition: normal release, timeout_o=0.
  - done_i together with a dropped req: a single release.
  - New requests arriving during HOLD are not considered until IDLE.
  - Requests that drop while in IDLE are never granted, since sampling happens at the edge.
- Fairness: a continuously asserted request is granted within 3 other grants.
- Reset mid-operation: rst_i low forces all outputs and state to reset values immediately, without waiting for a clock edge. After reset the pointer restarts at 0.
- Invariants:
  - grant_o is always zero or one-hot.
  - busy_o == |grant_o.
  - When busy_o=1, sel_o equals the index of grant_o.

Test Plan:
1. Rotation and wrap:
   - Stimulus: after reset hold req_i=4'b1111, pulse done_i for one cycle in each HOLD.
   - Required: grants 0001 (sel 0), 0010 (sel 1), 0100 (sel 2), 1000 (sel 3), then 0001 again.
   - Required: one idle cycle with grant_o=0 between each grant.
2. Single requester with wrapped search:
   - Stimulus: req_i=4'b0100 held, done_i after 3 cycles.
   - Required: first grant 0100 one cycle after req; after release ptr=3, and the next grant is 0100 again following a one-cycle bubble.
3. Timeout (MAX_HOLD=15):
   - Stimulus: req_i=4'b0001 held, done_i=0.
   - Required: grant_o=0001 for exactly 15 cycles, then grant_o=0 with timeout_o=1 for one cycle, then a re-grant of 0001.
4. Request drop:
   - Stimulus: the owner deasserts its req mid-HOLD.
   - Required: grant_o=0 at the next edge, timeout_o=0, sel_o unchanged.
5. done_i coincident with the timeout cycle:
   - Stimulus: done_i=1 on cycle 15 of a hold.
   - Required: release with timeout_o=0.
6. Asynchronous reset mid-HOLD:
   - Stimulus: drop rst_i between edges while grant_o=1000.
   - Required: grant_o, sel_o and busy_o read 0 immediately.
   - Required: after release with req_i=1111, the first grant is 0001.
